mem_arbiter: RTL and testbench

- Shares the single external memory port between the I-cache and D-cache miss/write-back paths of the pipelined MIPS core.
- Sits between the two caches and the memory model.
- Sequences one line transaction at a time with a small FSM and returns data plus a one-cycle ready pulse to the winning cache.
- Fixed D-over-I priority, with a starvation guard for the instruction side.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int STARVE_W   = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: D wins over I unless I has been passed over STARVE_LIMIT times.
// Latency: purely combinational.
// Backpressure: none; the caller only samples the grants while idle.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve,
  output logic                grant_i,
  output logic                grant_d
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic i_forced;

  // I is forced through only when it is waiting and the counter has saturated.
  always_comb begin
    i_forced = i_req && (starve == LIMIT);
    grant_d  = d_req && !i_forced;
    grant_i  = i_req && !grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache, one transaction at a time.
// Latency: strobe registered on the grant edge; x_ready one cycle after mem_ready; one RESP + one IDLE cycle between grants.
// Backpressure: losing requester simply holds its level request; optional MEM_ARB_PERF_EN adds wait-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  state_t              state;
  state_t              state_nxt;
  logic [STARVE_W-1:0] starve;
  logic                d_req;
  logic                grant_i;
  logic                grant_d;

  assign d_req = d_read | d_write;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_req   (i_read),
    .d_req   (d_req),
    .starve  (starve),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: grant from IDLE, wait for memory, one response cycle, back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side strobes/address/data and the cache-side return path, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      // Ready is a single-cycle pulse; only the completion edge raises it.
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_read  <= d_read;
            mem_write <= d_write;
          end else if (grant_i) begin
            mem_addr  <= i_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            i_rdata  <= mem_rdata;
            i_ready  <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // A write-back returns no data, so the D line keeps its last read value.
            if (mem_read) d_rdata <= mem_rdata;
            d_ready   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Count D grants that jumped ahead of a waiting I; any I grant clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (grant_d && i_read) begin
        if (starve != LIMIT) starve <= starve + 1'b1;
      end else if (grant_i) begin
        starve <= '0;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic i_waiting;
  logic d_waiting;

  // A side is being served while its BUSY state is active or its ready pulse is up (RESP).
  assign i_waiting = i_read && (state != BUSY_I) && !i_ready;
  assign d_waiting = d_req  && (state != BUSY_D) && !d_ready;

  // Free-running wait-cycle counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_wait <= '0;
      perf_d_wait <= '0;
    end else begin
      if (i_waiting) perf_i_wait <= perf_i_wait + 32'd1;
      if (d_waiting) perf_d_wait <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads, write-back, priority, starvation, spurious ready.
// Latency: checks strobe on the grant edge and ready one edge after mem_ready.
// Backpressure: memory ready is driven by hand with a per-transaction latency.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_i_wait;
  logic [31:0]   perf_d_wait;
  logic [31:0]   perf_snap;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_wait (perf_i_wait),
    .perf_d_wait (perf_d_wait)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s/ctl", tag), {mem_read, mem_write, i_ready, d_ready}, 4'b0000);
    check($sformatf("%s/addr", tag), mem_addr, '0);
    check($sformatf("%s/wdata", tag), mem_wdata, '0);
    check($sformatf("%s/i_rdata", tag), i_rdata, '0);
    check($sformatf("%s/d_rdata", tag), d_rdata, '0);
  endtask

  // One complete transaction starting from IDLE: grant edge, lat busy cycles, ready, RESP.
  task automatic serve(input string tag, input bit side_d, input bit wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                       input logic [DW-1:0] rd, input int lat, input bit drop, input bit spur);
    cyc();
    check($sformatf("%s/strobe", tag), {mem_write, mem_read}, {wr, !wr});
    check($sformatf("%s/addr", tag), mem_addr, addr);
    if (wr) check($sformatf("%s/wdata", tag), mem_wdata, wdat);
    for (int k = 1; k < lat; k++) begin
      cyc();
      check($sformatf("%s/hold%0d", tag, k), {mem_write, mem_read, mem_addr}, {wr, !wr, addr});
      check($sformatf("%s/noready%0d", tag, k), {i_ready, d_ready}, 2'b00);
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    cyc();
    mem_ready = spur;
    mem_rdata = ~rd;
    if (!wr) begin
      if (side_d) exp_d_rdata = rd;
      else        exp_i_rdata = rd;
    end
    check($sformatf("%s/ready", tag), {i_ready, d_ready}, {!side_d, side_d});
    check($sformatf("%s/i_rdata", tag), i_rdata, exp_i_rdata);
    check($sformatf("%s/d_rdata", tag), d_rdata, exp_d_rdata);
    check($sformatf("%s/strobe_off", tag), {mem_write, mem_read}, 2'b00);
    if (drop) begin
      if (side_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
    cyc();
    mem_ready = 1'b0;
    check($sformatf("%s/ready_off", tag), {i_ready, d_ready}, 2'b00);
  endtask

  initial begin
    rst       = 1'b1;
    i_read    = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    #12;
    check_all_zero("reset");
    cyc();
    rst = 1'b0;
    cyc();
    check_all_zero("post_reset");

    // Single I read, memory answers three cycles after the strobe.
    i_read = 1'b1;
    i_addr = 28'h0000010;
    serve("i_single", 1'b0, 1'b0, 28'h0000010, '0,
          128'hDEADBEEF_00000000_00000000_00000001, 3, 1'b1, 1'b0);

    // Both request in IDLE with a clear counter: D first, then I.
    i_read = 1'b1;
    i_addr = 28'h0000100;
    d_read = 1'b1;
    d_addr = 28'h0000200;
    serve("simul_d", 1'b1, 1'b0, 28'h0000200, '0,
          128'h11111111_22222222_33333333_44444444, 2, 1'b1, 1'b0);
    check("starve_after_d", dut.starve, 4'd1);
    serve("simul_i", 1'b0, 1'b0, 28'h0000100, '0,
          128'h55555555_66666666_77777777_88888888, 2, 1'b1, 1'b0);
    check("starve_after_i", dut.starve, 4'd0);

    // Write-back with a five-cycle memory; d_rdata must keep the earlier read line.
    d_write = 1'b1;
    d_addr  = 28'h0ABCDEF;
    d_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    serve("d_write", 1'b1, 1'b1, 28'h0ABCDEF,
          128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
          128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0, 5, 1'b1, 1'b0);

    // Starvation: I held, D keeps requesting; four D grants, then I.
    i_read = 1'b1;
    i_addr = 28'h0000111;
    d_read = 1'b1;
    d_addr = 28'h0000222;
`ifdef MEM_ARB_PERF_EN
    perf_snap = perf_i_wait;
`endif
    for (int n = 0; n < 4; n++) begin
      serve($sformatf("starve_d%0d", n), 1'b1, 1'b0, 28'h0000222, '0,
            {96'h0, 32'hA000_0000 + 32'(n)}, 2, 1'b0, 1'b0);
    end
    check("starve_sat", dut.starve, 4'd4);
    serve("starve_i", 1'b0, 1'b0, 28'h0000111, '0,
          128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D, 2, 1'b1, 1'b0);
    d_read = 1'b0;
    check("starve_clear", dut.starve, 4'd0);
`ifdef MEM_ARB_PERF_EN
    check("perf_i_wait", perf_i_wait - perf_snap, 32'd17);
`endif

    // Spurious mem_ready while IDLE: nothing moves.
    mem_ready = 1'b1;
    mem_rdata = 128'hFFFF;
    cyc();
    cyc();
    check("spur_idle/ctl", {mem_read, mem_write, i_ready, d_ready}, 4'b0000);
    check("spur_idle/i_rdata", i_rdata, exp_i_rdata);
    mem_ready = 1'b0;

    // Spurious mem_ready held through RESP: still only one ready pulse.
    i_read = 1'b1;
    i_addr = 28'h0000333;
    serve("spur_resp", 1'b0, 1'b0, 28'h0000333, '0,
          128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F, 1, 1'b1, 1'b1);
    cyc();
    check("spur_resp/after", {mem_read, i_ready, d_ready}, 3'b000);

    // Reset in the middle of a write-back.
    d_write = 1'b1;
    d_addr  = 28'h0000444;
    d_wdata = 128'h44444444;
    cyc();
    check("rst_mid/write", mem_write, 1'b1);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_async");
    d_write = 1'b0;
    cyc();
    rst = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    cyc();
    check_all_zero("rst_mid_rel1");
    cyc();
    check_all_zero("rst_mid_rel2");

    // After reset the arbiter accepts a fresh request from IDLE.
    i_read = 1'b1;
    i_addr = 28'h0000555;
    serve("post_rst_i", 1'b0, 1'b0, 28'h0000555, '0,
          128'h5555_AAAA, 2, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
